// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one 256x16 memory port between cpu fetch and host
// Host bursts are capped at BURST_MAX grants while cpu_req waits; read data is tagged back to its owner.
module mem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_burst,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            BW   = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);

  logic          last;
  logic [BW-1:0] bcnt;
  logic          rd_valid;
  logic          rd_owner;
  logic [DW-1:0] cpu_hold;
  logic [DW-1:0] host_hold;
  logic          burst_hold;

  // bcnt is nonzero exactly when the host owned the previous cycle
  always_comb begin
    cpu_gnt    = 1'b0;
    host_gnt   = 1'b0;
    burst_hold = (bcnt != '0) && host_burst && (bcnt < BMAX);
    if (rst) begin
      if (cpu_req && host_req) begin
        host_gnt = burst_hold || !last;
        cpu_gnt  = !host_gnt;
      end else begin
        cpu_gnt  = cpu_req;
        host_gnt = host_req;
      end
    end
  end

  assign mem_en    = cpu_gnt | host_gnt;
  assign mem_we    = host_gnt & host_we;
  assign mem_addr  = host_gnt ? host_addr : cpu_addr;
  assign mem_wdata = host_wdata;

  assign cpu_rvalid  = rd_valid & ~rd_owner;
  assign host_rvalid = rd_valid & rd_owner;
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : cpu_hold;
  assign host_rdata  = host_rvalid ? mem_rdata : host_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last      <= 1'b1;
      bcnt      <= '0;
      rd_valid  <= 1'b0;
      rd_owner  <= 1'b0;
      cpu_hold  <= '0;
      host_hold <= '0;
    end else begin
      if (mem_en)
        last <= host_gnt;
      if (host_gnt)
        bcnt <= (bcnt == BMAX) ? BMAX : bcnt + BW'(1);
      else
        bcnt <= '0;
      rd_valid <= mem_en & ~mem_we;
      rd_owner <= host_gnt;
      if (cpu_rvalid)
        cpu_hold <= mem_rdata;
      if (host_rvalid)
        host_hold <= mem_rdata;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 256x16 program/data memory between the processor fetch path (read-only) and a host loader/debug port (read/write). It sits between the processor, the host interface and the memory array, and drives the memory's only access port. Arbitration is round-robin, with a bounded host burst mode so program loading is fast but cannot starve instruction fetch. Read data returns one cycle after grant and is tagged to the requester that owns it.

## Interface
- AW, 8, memory address width (256 words)
- DW, 16, memory data width
- BURST_MAX, 4, max consecutive host grants while cpu_req is pending (>=1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- cpu_req  in  1  processor read request; held with cpu_addr until cpu_gnt
- cpu_addr  in  AW  processor read address
- cpu_gnt  out  1  request accepted this cycle (combinational)
- cpu_rvalid  out  1  cpu_rdata valid (registered)
- cpu_rdata  out  DW  read data
- host_req  in  1  host request; held with addr/we/wdata until host_gnt
- host_we  in  1  1 = write, 0 = read
- host_burst  in  1  request to retain grant on consecutive cycles
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_gnt  out  1  request accepted this cycle (combinational)
- host_rvalid  out  1  host_rdata valid (registered, reads only)
- host_rdata  out  DW  read data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  synchronous-read data, valid the cycle after mem_en & !mem_we

## Operation
- At most one grant per cycle; mem_en = cpu_gnt | host_gnt; mem_addr/we/wdata are muxed from the granted requester; mem_we only when host_gnt & host_we.
- Only one requester: it is granted immediately.
- Both requesters: the one not granted last wins (last-grant pointer `last`, 0 = cpu, 1 = host). Exception: host burst.
- Host burst: if host was granted in the previous cycle and host_req & host_burst are high, host keeps priority while burst count `bcnt` < BURST_MAX. When `bcnt` reaches BURST_MAX and cpu_req is high, cpu gets the next grant. If cpu_req is low, the host continues; `bcnt` saturates at BURST_MAX.
- `bcnt`: set to 1 on a host grant following a non-host cycle; incremented (saturating) on consecutive host grants; cleared on any cycle without host_gnt.
- Read return: a 1-bit owner tag plus a valid flag are registered with each read grant. The next cycle, the owner's rvalid is asserted and its rdata = mem_rdata. Writes produce no rvalid.
- rdata outputs hold their last value when rvalid is low.
- Idle (no requests): mem_en = 0; `last` and `bcnt` are unchanged except that `bcnt` clears.

## Timing
- Reset (rst = 0, async): cpu_rvalid = host_rvalid = 0; cpu_rdata = host_rdata = 0; `last` = 1 (cpu wins the first tie); `bcnt` = 0; in-flight read discarded. While rst = 0, cpu_gnt = host_gnt = mem_en = mem_we = 0 regardless of requests.
- Deassertion of reset is synchronous to clk; the first grant is possible in the first cycle with rst = 1.
- Grant latency 0 cycles (same cycle as request). Read latency is 1 cycle from grant to rvalid. Throughput is one access per cycle.
- Back-to-back reads by the same requester return in order, one per cycle.
- A host write at cycle N followed by a cpu read of the same address at N+1 returns the new data.
- A reset asserted in the cycle after a read grant suppresses that rvalid.

## Test plan
- Reset: hold rst = 0 with cpu_req = host_req = 1 -> gnt = 0, mem_en = 0, rvalid = 0, rdata = 0; release -> cpu_gnt = 1 first cycle.
- CPU read: mem[0x05] = 0x0812, cpu_req at addr 0x05 in cycle N -> cpu_gnt = 1 and mem_addr = 0x05 at N; cpu_rvalid = 1 and cpu_rdata = 0x0812 at N+1; host_rvalid = 0.
- Contention, no burst: both requesting continuously for 6 cycles -> grants cpu, host, cpu, host, cpu, host; each rvalid routed to the correct owner.
- Burst (BURST_MAX = 4): host_burst = 1 and both requesting continuously -> cpu, host x4, cpu, host x4. With cpu_req = 0 -> host granted every cycle.
- Write-then-read: host writes 0xC105 to 0x10 at N, cpu reads 0x10 at N+1 -> mem_we = 1 only at N; cpu_rdata = 0xC105 at N+2; no host_rvalid.
- Reset mid-read: cpu read granted at N, rst = 0 during N+1 -> cpu_rvalid stays 0; after release, a normal read completes.
